// File: rtl/id_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_issue_stage
// Brief    : Decode-to-execute issue stage with operand forwarding, load-use
//            hazard detection and a 2-entry skid buffer toward EX.
// Revision : 1.0 - initial release
// ============================================================================
module id_issue_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 3,
  parameter int CTRL_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [ADDR_W-1:0]         in_ra_addr,
  input  logic [ADDR_W-1:0]         in_rb_addr,
  input  logic [1:0]                in_src_used,
  input  logic [ADDR_W-1:0]         in_dst_addr,
  input  logic                      in_gpr_we_,
  input  logic [DATA_W-1:0]         gpr_rd_data_0,
  input  logic [DATA_W-1:0]         gpr_rd_data_1,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_we_,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [DATA_W-1:0]         out_ra_data,
  output logic [DATA_W-1:0]         out_rb_data,
  output logic [ADDR_W-1:0]         out_ra_addr,
  output logic [ADDR_W-1:0]         out_rb_addr,
  output logic [ADDR_W-1:0]         out_dst_addr,
  output logic                      out_gpr_we_,
  output logic                      hazard_stall
);

  localparam int ENT_W = CTRL_W + 2*DATA_W + 3*ADDR_W + 1;

  logic [DATA_W-1:0] ra_fwd, rb_fwd;
  logic              ra_hit, rb_hit, ra_load, rb_load;
  logic              hazard, accept, pop, main_we_;
  logic [ENT_W-1:0]  new_entry;

  logic [ENT_W-1:0]  main_d, main_q, skid_d, skid_q;
  logic              main_valid_d, main_valid_q;
  logic              skid_valid_d, skid_valid_q;

  // Walk from oldest to youngest so the lowest matching index is the last writer.
  always_comb begin
    ra_fwd  = gpr_rd_data_0;
    rb_fwd  = gpr_rd_data_1;
    ra_hit  = 1'b0;
    rb_hit  = 1'b0;
    ra_load = 1'b0;
    rb_load = 1'b0;
    for (int i = NUM_FWD-1; i >= 0; i--) begin
      if (fwd_valid[i] && !fwd_we_[i] && (in_ra_addr != '0) &&
          (fwd_addr[i*ADDR_W +: ADDR_W] == in_ra_addr)) begin
        ra_fwd  = fwd_data[i*DATA_W +: DATA_W];
        ra_hit  = 1'b1;
        ra_load = fwd_is_load[i];
      end
      if (fwd_valid[i] && !fwd_we_[i] && (in_rb_addr != '0) &&
          (fwd_addr[i*ADDR_W +: ADDR_W] == in_rb_addr)) begin
        rb_fwd  = fwd_data[i*DATA_W +: DATA_W];
        rb_hit  = 1'b1;
        rb_load = fwd_is_load[i];
      end
    end
  end

  assign hazard       = (in_src_used[0] & ra_hit & ra_load) |
                        (in_src_used[1] & rb_hit & rb_load);
  assign hazard_stall = in_valid & hazard;
  assign in_ready     = ~skid_valid_q & ~hazard;
  assign accept       = in_valid & in_ready & ~flush;
  assign pop          = main_valid_q & out_ready;

  assign new_entry = {in_ctrl, ra_fwd, rb_fwd, in_ra_addr, in_rb_addr,
                      in_dst_addr, in_gpr_we_};

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop) begin
      // Skid full implies in_ready=0, so no accept can coincide with a skid drain.
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = new_entry;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_d       = new_entry;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = new_entry;
        main_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign {out_ctrl, out_ra_data, out_rb_data, out_ra_addr, out_rb_addr,
          out_dst_addr, main_we_} = main_q;
  assign out_valid   = main_valid_q;
  assign out_gpr_we_ = main_we_ | ~main_valid_q;

endmodule
`default_nettype wire
